// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Purpose  : Word RAM with 1-cycle registered read, bit-masked write, sticky
//            out-of-range fault, tohost halt register and an optional
//            post-reset clear sequencer (MEMORY_RESPONDER_CLEAR_EN).
// Revision : 1.0
// ============================================================================
module memory_responder #(
    parameter logic [31:0] START_ADDRESS  = 32'h0000_0000,
    parameter int          DEPTH          = 1024,
    parameter logic [31:0] TOHOST_ADDRESS = 32'h0000_1000,
    parameter string       INIT_FILE      = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_memory_address,
    output logic [31:0] read_memory_data,
    input  logic        write_memory_enable,
    input  logic [31:0] write_memory_address,
    input  logic [31:0] write_memory_data,
    input  logic [31:0] write_memory_mask,
    output logic        ready,
    output logic        fault,
    output logic [31:0] fault_address,
    output logic        halt,
    output logic [31:0] tohost
);

    localparam int          C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] C_BYTES = 33'(DEPTH) << 2;

    logic [31:0]     r_mem [DEPTH];
    logic            r_ready;
    logic            r_halt;
    logic            r_fault;
    logic [31:0]     r_rdata;
    logic [31:0]     r_tohost;
    logic [31:0]     r_fault_addr;

    logic [31:0]     w_roff;
    logic [31:0]     w_woff;
    logic [C_AW-1:0] w_ridx;
    logic [C_AW-1:0] w_widx;
    logic            w_act;
    logic            w_rd_ram;
    logic            w_wr_ram;
    logic            w_rd_host;
    logic            w_wr_host;
    logic            w_wr_go;
    logic            w_rd_fault;
    logic            w_wr_fault;
    logic [31:0]     w_wmerge;
    logic [31:0]     w_hmerge;

    // Offsets wrap below START_ADDRESS, so one unsigned compare covers both bounds.
    assign w_roff     = read_memory_address - START_ADDRESS;
    assign w_woff     = write_memory_address - START_ADDRESS;
    assign w_rd_ram   = ({1'b0, w_roff} < C_BYTES);
    assign w_wr_ram   = ({1'b0, w_woff} < C_BYTES);
    assign w_ridx     = w_roff[C_AW+1:2];
    assign w_widx     = w_woff[C_AW+1:2];
    assign w_rd_host  = (read_memory_address == TOHOST_ADDRESS);
    assign w_wr_host  = (write_memory_address == TOHOST_ADDRESS);

    assign w_act      = reset & r_ready;
    assign w_wr_go    = w_act & write_memory_enable & ~r_halt;
    assign w_wmerge   = (r_mem[w_widx] & ~write_memory_mask) | (write_memory_data & write_memory_mask);
    assign w_hmerge   = (r_tohost & ~write_memory_mask) | (write_memory_data & write_memory_mask);
    assign w_rd_fault = w_act & ~w_rd_ram & ~w_rd_host;
    assign w_wr_fault = w_wr_go & ~w_wr_ram & ~w_wr_host;

`ifdef MEMORY_RESPONDER_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [C_AW-1:0] C_LAST = C_AW'(DEPTH - 1);

    state_t          r_state;
    logic [C_AW-1:0] r_cnt;
    logic            w_clr_we;

    assign w_clr_we = reset & (r_state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_go && w_wr_ram) begin
            r_mem[w_widx] <= w_wmerge;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_wr_go && w_wr_ram) begin
            r_mem[w_widx] <= w_wmerge;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready      <= 1'b0;
            r_rdata      <= '0;
            r_halt       <= 1'b0;
            r_tohost     <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
`ifdef MEMORY_RESPONDER_CLEAR_EN
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
`endif
        end else begin
`ifdef MEMORY_RESPONDER_CLEAR_EN
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    r_state <= ST_READY;
                    r_ready <= 1'b1;
                end
            end
`else
            r_ready <= 1'b1;
`endif
            // Write-first: a same-cycle write to the read target is forwarded.
            if (!r_ready) begin
                r_rdata <= '0;
            end else if (w_rd_ram) begin
                r_rdata <= (w_wr_go && w_wr_ram && (w_ridx == w_widx)) ? w_wmerge : r_mem[w_ridx];
            end else if (w_rd_host) begin
                r_rdata <= (w_wr_go && w_wr_host) ? w_hmerge : r_tohost;
            end else begin
                r_rdata <= '0;
            end

            if (w_wr_go && w_wr_host) begin
                r_tohost <= w_hmerge;
                if (|write_memory_mask) begin
                    r_halt <= 1'b1;
                end
            end

            if (!r_fault && (w_rd_fault || w_wr_fault)) begin
                r_fault      <= 1'b1;
                r_fault_addr <= w_wr_fault ? write_memory_address : read_memory_address;
            end
        end
    end

    assign read_memory_data = r_rdata;
    assign ready            = r_ready;
    assign fault            = r_fault;
    assign fault_address    = r_fault_addr;
    assign halt             = r_halt;
    assign tohost           = r_tohost;

endmodule
`default_nettype wire
